// File: rtl/wisc_pkg.sv
// Shared definitions for the hart's data-side load/store path: access size codes, LSU states
// and the alignment rule.
package wisc_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_e;

  // Illegal size is folded in so one flag decides "trap without touching memory".
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store mask and data shift, and load extraction with
// sign/zero extension.
module lsu_align
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        mask,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] wdata_sz;
  logic [DATA_W-1:0] rdata_sh;

  assign shamt    = {off, 3'b000};
  assign wdata_sh = wdata_sz << shamt;
  assign rdata_sh = rdata >> shamt;

  always_comb begin
    mask      = 4'b0000;
    wdata_sz  = '0;
    rdata_ext = '0;
    case (size)
      SIZE_B: begin
        mask      = 4'b0001 << off;
        wdata_sz  = {{(DATA_W-8){1'b0}}, wdata[7:0]};
        rdata_ext = {{(DATA_W-8){~is_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
      end
      SIZE_H: begin
        mask      = 4'b0011 << off;
        wdata_sz  = {{(DATA_W-16){1'b0}}, wdata[15:0]};
        rdata_ext = {{(DATA_W-16){~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
      end
      SIZE_W: begin
        mask      = 4'b1111;
        wdata_sz  = wdata;
        rdata_ext = rdata_sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit between the hart data port and a valid/ready memory bus.
// Misaligned or illegal requests trap without issuing a memory access.
module dmem_lsu
  import wisc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_trap,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_rsp_valid,
  input  logic [DATA_W-1:0] i_mem_rsp_rdata
);

  lsu_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        size_q;
  logic              wen_q;
  logic              uns_q;
  logic              trap_q;

  logic              accept;
  logic              mem_done;
  logic [3:0]        mask;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rdata_ext;

  assign accept   = (state_q == StIdle) && i_req_valid;
  // A response in REQ only counts when the request handshake completes in the same cycle.
  assign mem_done = ((state_q == StReq) && i_mem_req_ready && i_mem_rsp_valid) ||
                    ((state_q == StWait) && i_mem_rsp_valid);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= 2'b00;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        size_q  <= i_req_size;
        wen_q   <= i_req_wen;
        uns_q   <= i_req_unsigned;
        trap_q  <= is_misaligned(i_req_size, i_req_addr[1:0]);
      end
      if (mem_done) begin
        rdata_q <= i_mem_rsp_rdata;
      end
    end
  end

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size       (size_q),
    .off        (addr_q[1:0]),
    .is_unsigned(uns_q),
    .wdata      (wdata_q),
    .rdata      (rdata_q),
    .mask       (mask),
    .wdata_sh   (wdata_sh),
    .rdata_ext  (rdata_ext)
  );

  always_comb begin
    state_d         = state_q;
    o_req_ready     = 1'b0;
    o_rsp_valid     = 1'b0;
    o_rsp_rdata     = '0;
    o_rsp_trap      = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_addr      = '0;
    o_mem_wen       = 1'b0;
    o_mem_wdata     = '0;
    o_mem_mask      = 4'b0000;
    case (state_q)
      StIdle: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_d = is_misaligned(i_req_size, i_req_addr[1:0]) ? StResp : StReq;
        end
      end
      StReq: begin
        o_mem_req_valid = 1'b1;
        o_mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
        o_mem_wen       = wen_q;
        o_mem_wdata     = wdata_sh;
        o_mem_mask      = mask;
        if (i_mem_req_ready) begin
          state_d = i_mem_rsp_valid ? StResp : StWait;
        end
      end
      StWait: begin
        if (i_mem_rsp_valid) begin
          state_d = StResp;
        end
      end
      StResp: begin
        o_rsp_valid = 1'b1;
        o_rsp_trap  = trap_q;
        o_rsp_rdata = (wen_q || trap_q) ? '0 : rdata_ext;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized traffic, with the bench
// acting as the memory and predicting results from byte-lane arithmetic.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wen;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_trap;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_wen      (i_req_wen),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_trap     (o_rsp_trap),
    .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wen      (o_mem_wen),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_mask     (o_mem_mask),
    .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_rdata(i_mem_rsp_rdata)
  );

  // Reference model: plain byte arithmetic on the access description.
  function automatic logic model_trap(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [31:0] addr);
    int lanes;
    lanes = (size == 2'd0) ? 1 : (size == 2'd1) ? 3 : 15;
    if (size == 2'd2) return 4'hF;
    return 4'(lanes << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] wdata);
    logic [31:0] keep;
    keep = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (wdata & keep) << (8 * (addr % 4));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic uns, input logic [31:0] word);
    logic [31:0] w;
    w = word >> (8 * (addr % 4));
    if (size == 2'd0) begin
      if (!uns && w[7]) return w | 32'hFFFF_FF00;
      return w & 32'h0000_00FF;
    end
    if (size == 2'd1) begin
      if (!uns && w[15]) return w | 32'hFFFF_0000;
      return w & 32'h0000_FFFF;
    end
    return w;
  endfunction

  // One complete transaction: drives the hart side, plays the memory, checks every cycle.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int rdy_dly,
                         input int rsp_dly, input logic [31:0] word, input string name);
    logic        exp_trap;
    logic [31:0] exp_rd;
    logic [69:0] exp_bus;
    exp_trap = model_trap(size, addr);
    exp_rd   = (wen || exp_trap) ? 32'h0 : model_load(size, addr, uns, word);
    exp_bus  = {1'b1, wen, addr & 32'hFFFF_FFFC, model_mask(size, addr),
                model_wdata(size, addr, wdata)};

    @(negedge clk);
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL %s idle_ready got %b want 1", name, o_req_ready);
    end
    i_req_valid    = 1'b1;
    i_req_wen      = wen;
    i_req_addr     = addr;
    i_req_wdata    = wdata;
    i_req_size     = size;
    i_req_unsigned = uns;
    @(posedge clk);
    #1;
    i_req_valid    = 1'b0;
    i_req_wen      = 1'($urandom);
    i_req_addr     = $urandom;
    i_req_wdata    = $urandom;
    i_req_size     = 2'($urandom);
    i_req_unsigned = 1'($urandom);

    if (exp_trap) begin
      @(negedge clk);
      n_checks++;
      if ({o_rsp_valid, o_rsp_trap, o_rsp_rdata, o_mem_req_valid, o_req_ready} !==
          {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
        n_fails++;
        $display("FAIL %s trap_rsp got v=%b t=%b d=%h memv=%b rdy=%b want v=1 t=1 d=0 memv=0 rdy=0",
                 name, o_rsp_valid, o_rsp_trap, o_rsp_rdata, o_mem_req_valid, o_req_ready);
      end
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        @(negedge clk);
        n_checks++;
        if ({o_mem_req_valid, o_mem_wen, o_mem_addr, o_mem_mask, o_mem_wdata} !== exp_bus) begin
          n_fails++;
          $display("FAIL %s mem_bus cyc%0d got %h want %h", name, i,
                   {o_mem_req_valid, o_mem_wen, o_mem_addr, o_mem_mask, o_mem_wdata}, exp_bus);
        end
        n_checks++;
        if ({o_req_ready, o_rsp_valid} !== 2'b00) begin
          n_fails++;
          $display("FAIL %s req_busy got rdy=%b rsp=%b want 0 0", name, o_req_ready, o_rsp_valid);
        end
        if (i == rdy_dly) begin
          i_mem_req_ready = 1'b1;
          i_mem_rsp_valid = (rsp_dly == 0);
          i_mem_rsp_rdata = (rsp_dly == 0) ? word : $urandom;
        end else begin
          // Responses without the request handshake must be ignored.
          i_mem_req_ready = 1'b0;
          i_mem_rsp_valid = 1'($urandom);
          i_mem_rsp_rdata = $urandom;
        end
      end
      for (int j = 1; j <= rsp_dly; j++) begin
        @(negedge clk);
        i_mem_req_ready = 1'b0;
        n_checks++;
        if ({o_mem_req_valid, o_rsp_valid, o_req_ready} !== 3'b000) begin
          n_fails++;
          $display("FAIL %s wait_state got memv=%b rsp=%b rdy=%b want 0 0 0", name,
                   o_mem_req_valid, o_rsp_valid, o_req_ready);
        end
        i_mem_rsp_valid = (j == rsp_dly);
        i_mem_rsp_rdata = (j == rsp_dly) ? word : $urandom;
      end
      @(negedge clk);
      i_mem_req_ready = 1'b0;
      i_mem_rsp_valid = 1'($urandom);
      i_mem_rsp_rdata = $urandom;
      n_checks++;
      if ({o_rsp_valid, o_rsp_trap, o_rsp_rdata, o_req_ready, o_mem_req_valid} !==
          {1'b1, 1'b0, exp_rd, 1'b0, 1'b0}) begin
        n_fails++;
        $display("FAIL %s rsp got v=%b t=%b d=%h rdy=%b memv=%b want v=1 t=0 d=%h rdy=0 memv=0",
                 name, o_rsp_valid, o_rsp_trap, o_rsp_rdata, o_req_ready, o_mem_req_valid, exp_rd);
      end
    end

    @(negedge clk);
    i_mem_rsp_valid = 1'b0;
    n_checks++;
    if ({o_rsp_valid, o_req_ready, o_mem_req_valid} !== 3'b010) begin
      n_fails++;
      $display("FAIL %s after_rsp got rsp=%b rdy=%b memv=%b want 0 1 0", name, o_rsp_valid,
               o_req_ready, o_mem_req_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap, o_mem_req_valid, o_mem_addr,
         o_mem_wen, o_mem_wdata, o_mem_mask} !== {1'b1, 104'h0}) begin
      n_fails++;
      $display("FAIL %s reset_outputs got rdy=%b rsp=%b d=%h t=%b memv=%b a=%h w=%b wd=%h m=%b",
               name, o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap, o_mem_req_valid,
               o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_size = 2'b00; i_req_unsigned = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_rdata = '0;
    #1;
    check_reset_outputs("reset_t0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    i_rst = 1'b0;
  endtask

  task automatic test_directed;
    run_txn(1'b0, 32'h0000_1000, 32'h0, 2'd2, 1'b0, 0, 3, 32'hDEAD_BEEF, "lw");
    run_txn(1'b0, 32'h0000_1002, 32'h0, 2'd1, 1'b0, 0, 1, 32'h8001_1234, "lh");
    run_txn(1'b0, 32'h0000_1002, 32'h0, 2'd1, 1'b1, 1, 2, 32'h8001_1234, "lhu");
    run_txn(1'b1, 32'h0000_2003, 32'h0000_00AB, 2'd0, 1'b0, 0, 2, 32'h0, "sb");
    run_txn(1'b1, 32'h0000_2002, 32'h1234_5678, 2'd1, 1'b0, 0, 0, 32'h0, "sh_same_cycle");
  endtask

  task automatic test_trap;
    run_txn(1'b0, 32'h0000_1001, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0, "lw_misaligned");
    run_txn(1'b0, 32'h0000_1000, 32'h0, 2'd3, 1'b0, 0, 0, 32'h0, "size_illegal");
    run_txn(1'b1, 32'h0000_1003, 32'hFFFF, 2'd1, 1'b0, 0, 0, 32'h0, "sh_misaligned");
  endtask

  task automatic test_backpressure;
    run_txn(1'b1, 32'h0000_4001, 32'h0000_00C3, 2'd0, 1'b0, 4, 1, 32'h0, "sb_backpressure");
    run_txn(1'b0, 32'h0000_4000, 32'h0, 2'd2, 1'b0, 4, 0, 32'h0BAD_F00D, "lw_backpressure");
  endtask

  task automatic test_reset_mid;
    // Reset during REQ: bus drops without a clock edge.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_addr = 32'h0000_1000; i_req_size = 2'd2;
    i_req_unsigned = 1'b0;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_mem_req_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL mid_req memv got %b want 1", o_mem_req_valid);
    end
    #2 i_rst = 1'b1;
    #1 check_reset_outputs("reset_in_req");
    @(negedge clk);
    i_rst = 1'b0;
    // Reset during WAIT.
    i_req_valid = 1'b1;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    i_mem_req_ready = 1'b1;
    @(posedge clk);
    #1 i_mem_req_ready = 1'b0;
    #2;
    n_checks++;
    if ({o_req_ready, o_mem_req_valid, o_rsp_valid} !== 3'b000) begin
      n_fails++;
      $display("FAIL mid_wait state got rdy=%b memv=%b rsp=%b want 0 0 0", o_req_ready,
               o_mem_req_valid, o_rsp_valid);
    end
    i_rst = 1'b1;
    #1 check_reset_outputs("reset_in_wait");
    @(negedge clk);
    i_rst = 1'b0;
    run_txn(1'b0, 32'h0000_3001, 32'h0, 2'd0, 1'b1, 0, 2, 32'h0000_F000, "lbu_after_reset");
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 32'h0000_5000, 32'hCAFE_BABE, 2'd2, 1'b0, 0, 0, 32'h0, "b2b_sw");
    run_txn(1'b0, 32'h0000_5003, 32'h0, 2'd0, 1'b0, 0, 0, 32'h80FF_FFFF, "b2b_lb");
    run_txn(1'b0, 32'h0000_5001, 32'h0, 2'd1, 1'b0, 0, 0, 32'h0, "b2b_lh_trap");
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [1:0]  size;
    for (int k = 0; k < 60; k++) begin
      size = 2'($urandom_range(0, 3));
      if (size == 2'd3 && $urandom_range(0, 3) != 0) size = 2'd2;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      run_txn(1'($urandom), addr, $urandom, size, 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_trap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit that sits directly downstream of the hart's data-memory port.
- Takes one byte-addressed load/store request at a time.
- Performs alignment checking, byte-lane masking and store-data shifting.
- Drives a latency-tolerant valid/ready memory bus.
- Returns a sign/zero-extended load result, or a trap, to the hart with a one-cycle response pulse.
- Replaces the combinational dmem model used in phase 3.

Parameters:
ADDR_W, 32, byte address width on both sides.
DATA_W, 32, data width; fixed at 32, parameterised for readability only.

Ports:
i_clk  input  1  global clock
i_rst  input  1  reset, asynchronous, active-high
i_req_valid  input  1  hart presents a request this cycle
o_req_ready  output  1  LSU can accept a request (high only in IDLE)
i_req_wen  input  1  1 = store, 0 = load
i_req_addr  input  32  unaligned byte address
i_req_wdata  input  32  store value, right-justified
i_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
i_req_unsigned  input  1  zero-extend load result (lbu/lhu)
o_rsp_valid  output  1  one-cycle pulse; response fields valid
o_rsp_rdata  output  32  extended load data; 0 for stores and traps
o_rsp_trap  output  1  misaligned address or illegal size
o_mem_req_valid  output  1  memory request valid
i_mem_req_ready  input  1  memory accepts request
o_mem_addr  output  32  word-aligned address (addr[1:0] forced 0)
o_mem_wen  output  1  write request
o_mem_wdata  output  32  lane-shifted store data
o_mem_mask  output  4  byte-lane enables
i_mem_rsp_valid  input  1  memory response (read data or write ack)
i_mem_rsp_rdata  input  32  read word, valid in masked lanes only

Behaviour:
- Reset (async, any state): state = IDLE; all outputs 0 except o_req_ready = 1; latched request cleared.
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE: on i_req_valid, latch addr/wdata/size/wen/unsigned and compute mask/shift from the latched copy. The hart need not hold its inputs after acceptance.
  - Misaligned or illegal request (half with addr[0]=1, word with addr[1:0]!=0, size=11) goes to RESP with trap=1 and issues no memory access.
  - Any other request goes to REQ.
- REQ: o_mem_req_valid = 1 with addr/wen/wdata/mask stable. Stay in REQ while !i_mem_req_ready.
  - On ready, go to WAIT.
  - If ready and i_mem_rsp_valid arrive in the same cycle, go straight to RESP, capturing rdata.
- WAIT: o_mem_req_valid = 0. On i_mem_rsp_valid, capture rdata and go to RESP. No timeout.
- RESP: o_rsp_valid = 1 for exactly one cycle, then IDLE.
  - o_req_ready is 0 in RESP; a new request is accepted on the following IDLE cycle at the earliest.
- i_mem_rsp_valid in IDLE or RESP is ignored. In REQ it is honoured only together with ready.
- Mask rules, with off = addr[1:0]:
  - byte: 0001 << off
  - half: 0011 << off
  - word: 1111
- Store data is i_req_wdata << (8*off). Store bits outside the size are don't-care but are driven as zero.
- Load result:
  - Compute (rdata >> 8*off).
  - Truncate to the size, then sign-extend or zero-extend per i_req_unsigned.
  - The unsigned flag is ignored for word loads.
- Stores complete on the memory write ack and respond with rdata = 0, trap = 0.
- Latency from accept edge to o_rsp_valid:
  - Misaligned: 1 cycle.
  - Otherwise: 1 (REQ) + backpressure cycles + memory latency + 1.
- Only one request is in flight at a time.
- A reset while in REQ or WAIT abandons the access. The memory must be reset together with the LSU, so no stale response can arrive.

Decomposition:
- Shared package (wisc_pkg):
  - size encodings: SIZE_B, SIZE_H, SIZE_W
  - the LSU state enum
  - a function computing the misalignment flag
- One combinational sub-module, lsu_align: size, offset, wdata and rdata in; mask, shifted wdata and extended load data out. It is reused later by the pipelined hart's bypass checks.

Test Plan:
- lw at 0x1000, ready immediate, memory returns 0xDEADBEEF 3 cycles later -> o_mem_addr = 0x1000, mask 1111, wen 0; o_rsp_valid one cycle after rsp with rdata 0xDEADBEEF, trap 0.
- lh at 0x1002, memory word 0x8001_1234 -> mask 1100, rdata 0xFFFF8001; same with lhu -> 0x00008001.
- sb at 0x2003, wdata 0x000000AB -> o_mem_addr 0x2000, mask 1000, wdata 0xAB000000, wen 1; after ack, rsp rdata 0.
- lw at 0x1001 -> o_mem_req_valid never asserts; o_rsp_valid with trap = 1 in the cycle after accept; rdata 0. size = 11 gives the same result.
- i_mem_req_ready held low 4 cycles -> o_mem_req_valid and addr/mask/wdata stable all 4 cycles; o_req_ready low until the cycle after the rsp pulse.
- Reset asserted mid-WAIT -> outputs return to reset values without a clock edge; a subsequent lbu at 0x3001 of word 0x0000F000 completes with rdata 0x000000F0.
